// File: rtl/pll_pkg.sv
// Shared types, widths and default timing values for the PLL startup sequencer.
package pll_pkg;

  localparam int DIV_W  = 5;
  localparam int TRIM_W = 26;

  localparam int DEF_SETTLE_CYC  = 32;
  localparam int DEF_WIN_CYC     = 64;
  localparam int DEF_TOL         = 1;
  localparam int DEF_LOCK_WINS   = 2;
  localparam int DEF_TIMEOUT_WIN = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESET_HOLD,
    ST_SETTLE,
    ST_MEASURE,
    ST_LOCKED,
    ST_FALLBACK
  } pll_state_e;

  typedef struct packed {
    logic enable;
    logic resetb;
    logic dco;
    logic locked;
    logic fallback;
    logic busy;
  } pll_ctrl_t;

  // Single-bit controls are a pure function of state; the top registers them.
  function automatic pll_ctrl_t ctrl_for_state(input pll_state_e s);
    pll_ctrl_t c;
    c = '0;
    case (s)
      ST_RESET_HOLD: begin
        c.enable = 1'b1;
        c.busy   = 1'b1;
      end
      ST_SETTLE, ST_MEASURE: begin
        c.enable = 1'b1;
        c.resetb = 1'b1;
        c.busy   = 1'b1;
      end
      ST_LOCKED: begin
        c.enable = 1'b1;
        c.resetb = 1'b1;
        c.locked = 1'b1;
      end
      ST_FALLBACK: begin
        c.enable   = 1'b1;
        c.resetb   = 1'b1;
        c.dco      = 1'b1;
        c.fallback = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pll_freq_meter.sv
// Counts feedback ticks over back-to-back fixed windows and grades each window
// against the expected tick count.
module pll_freq_meter
  import pll_pkg::*;
#(
  parameter int WIN_CYC = DEF_WIN_CYC,
  parameter int TOL     = DEF_TOL
) (
  input  logic clock,
  input  logic reset,
  input  logic en_i,
  input  logic fb_tick_i,
  output logic win_done_o,
  output logic win_good_o
);

  localparam int WC_W = $clog2(WIN_CYC + 1);
  localparam int TK_W = $clog2(WIN_CYC) + 2;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(WIN_CYC - 1);
  localparam int LO = (WIN_CYC > TOL) ? (WIN_CYC - TOL) : 0;
  localparam int HI = WIN_CYC + TOL;

  logic [WC_W-1:0] win_cnt_q, win_cnt_d;
  logic [TK_W-1:0] tick_cnt_q, tick_cnt_d, tick_sum;

  // The grade uses the count including this cycle's tick, so a tick in the
  // final cycle of a window still belongs to that window.
  always_comb begin
    tick_sum = tick_cnt_q;
    if (fb_tick_i && (tick_cnt_q != {TK_W{1'b1}})) tick_sum = tick_cnt_q + 1'b1;
    win_done_o = en_i && (win_cnt_q == WC_LAST);
    win_good_o = win_done_o && (int'(tick_sum) >= LO) && (int'(tick_sum) <= HI);
    win_cnt_d  = win_cnt_q + 1'b1;
    tick_cnt_d = tick_sum;
    if (!en_i || win_done_o) begin
      win_cnt_d  = '0;
      tick_cnt_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      win_cnt_q  <= '0;
      tick_cnt_q <= '0;
    end else begin
      win_cnt_q  <= win_cnt_d;
      tick_cnt_q <= tick_cnt_d;
    end
  end

endmodule

// File: rtl/pll_startup_sequencer.sv
// Startup sequencer: holds the PLL in reset, lets it settle, measures lock
// over frequency windows and falls back to DCO mode if lock never arrives.
module pll_startup_sequencer
  import pll_pkg::*;
#(
  parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
  parameter int WIN_CYC     = DEF_WIN_CYC,
  parameter int TOL         = DEF_TOL,
  parameter int LOCK_WINS   = DEF_LOCK_WINS,
  parameter int TIMEOUT_WIN = DEF_TIMEOUT_WIN
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [TRIM_W-1:0] cfg_trim,
  input  logic              fb_tick,
  output logic              pll_enable,
  output logic              pll_resetb,
  output logic              pll_dco,
  output logic [DIV_W-1:0]  pll_div,
  output logic [TRIM_W-1:0] pll_ext_trim,
  output logic              locked,
  output logic              fallback,
  output logic              busy
);

  localparam int PH_W = $clog2(SETTLE_CYC + 1);
  localparam int GW   = $clog2(LOCK_WINS + 1);
  localparam int BW   = $clog2(TIMEOUT_WIN + 1);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(SETTLE_CYC - 1);

  pll_state_e        state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [GW-1:0]     good_q, good_d;
  logic [BW-1:0]     bad_q, bad_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [TRIM_W-1:0] trim_q, trim_d;
  pll_ctrl_t         ctrl_q, ctrl_d;
  logic              meter_en, win_done, win_good;

  assign meter_en = (state_q == ST_MEASURE) || (state_q == ST_LOCKED);

  pll_freq_meter #(
    .WIN_CYC (WIN_CYC),
    .TOL     (TOL)
  ) u_meter (
    .clock      (clock),
    .reset      (reset),
    .en_i       (meter_en),
    .fb_tick_i  (fb_tick),
    .win_done_o (win_done),
    .win_good_o (win_good)
  );

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    good_d  = good_q;
    bad_d   = bad_q;
    div_d   = div_q;
    trim_d  = trim_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          div_d   = cfg_div;
          trim_d  = cfg_trim;
          phase_d = '0;
          good_d  = '0;
          bad_d   = '0;
          state_d = (cfg_div < DIV_W'(2)) ? ST_FALLBACK : ST_RESET_HOLD;
        end
      end
      ST_RESET_HOLD, ST_SETTLE: begin
        phase_d = phase_q + 1'b1;
        if (phase_q == PH_LAST) begin
          phase_d = '0;
          state_d = (state_q == ST_RESET_HOLD) ? ST_SETTLE : ST_MEASURE;
        end
      end
      ST_MEASURE: begin
        if (win_done) begin
          if (win_good) begin
            good_d = good_q + 1'b1;
            if (int'(good_q) + 1 >= LOCK_WINS) begin
              good_d  = '0;
              state_d = ST_LOCKED;
            end
          end else begin
            good_d = '0;
            bad_d  = bad_q + 1'b1;
            if (int'(bad_q) + 1 >= TIMEOUT_WIN) state_d = ST_FALLBACK;
          end
        end
      end
      ST_LOCKED: begin
        // Losing lock keeps the accumulated bad-window count so a flaky PLL
        // still times out into DCO mode eventually.
        if (win_done && !win_good) begin
          good_d  = '0;
          state_d = ST_MEASURE;
        end
      end
      ST_FALLBACK: state_d = ST_FALLBACK;
      default:     state_d = ST_IDLE;
    endcase
    if (stop) begin
      state_d = ST_IDLE;
      phase_d = '0;
      good_d  = '0;
      bad_d   = '0;
      div_d   = '0;
      trim_d  = '0;
    end
    ctrl_d = ctrl_for_state(state_d);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      good_q  <= '0;
      bad_q   <= '0;
      div_q   <= '0;
      trim_q  <= '0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
      div_q   <= div_d;
      trim_q  <= trim_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign pll_enable   = ctrl_q.enable;
  assign pll_resetb   = ctrl_q.resetb;
  assign pll_dco      = ctrl_q.dco;
  assign locked       = ctrl_q.locked;
  assign fallback     = ctrl_q.fallback;
  assign busy         = ctrl_q.busy;
  assign pll_div      = div_q;
  assign pll_ext_trim = trim_q;

endmodule
